// File: rtl/test2_bist_pkg.sv
// Shared types and default constants for the test2 BIST controller and its MISR.
package test2_bist_pkg;

  localparam int               PAT_W    = 7;
  localparam int               SIG_W    = 16;
  localparam logic [SIG_W-1:0] SIG_POLY = 16'h1021;
  localparam logic [SIG_W-1:0] SIG_INIT = 16'hFFFF;
  localparam int               PAT_CNT  = 1 << PAT_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bist_misr.sv
// Serial-input multiple-input signature register: init loads SIG_INIT, shift_en compacts din.
module bist_misr
  import test2_bist_pkg::*;
#(
  parameter int               SIG_W    = test2_bist_pkg::SIG_W,
  parameter logic [SIG_W-1:0] SIG_POLY = test2_bist_pkg::SIG_POLY,
  parameter logic [SIG_W-1:0] SIG_INIT = test2_bist_pkg::SIG_INIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init,
  input  logic             shift_en,
  input  logic             din,
  output logic [SIG_W-1:0] sig
);

  logic fb;

  assign fb = sig[SIG_W-1] ^ din;

  // NOTE: reset is synchronous, so rst_n is tested inside the clocked block only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (init) begin
      sig <= SIG_INIT;
    end else if (shift_en) begin
      sig <= {sig[SIG_W-2:0], 1'b0} ^ (fb ? SIG_POLY : '0);
    end
  end

endmodule

// File: rtl/test2_bist_ctrl.sv
// Exhaustive stimulus/MISR-response BIST controller for the test2 netlist.
// Optional first-failure capture against the built-in model n = L[2]: define BIST_FAIL_CAPTURE_EN.
module test2_bist_ctrl
  import test2_bist_pkg::*;
#(
  parameter int               PAT_W    = test2_bist_pkg::PAT_W,
  parameter int               SIG_W    = test2_bist_pkg::SIG_W,
  parameter logic [SIG_W-1:0] SIG_POLY = test2_bist_pkg::SIG_POLY,
  parameter logic [SIG_W-1:0] SIG_INIT = test2_bist_pkg::SIG_INIT,
  parameter logic [SIG_W-1:0] EXP_SIG  = 16'h0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [3:0]       s,
  output logic [2:0]       L,
  input  logic             n,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature,
`ifdef BIST_FAIL_CAPTURE_EN
  output logic             fail_seen,
  output logic [PAT_W-1:0] first_fail_idx,
`endif
  output logic [PAT_W-1:0] pat_idx
);

  localparam logic [PAT_W-1:0] PAT_LAST = PAT_W'(PAT_CNT - 1);

  state_t           state;
  logic [PAT_W-1:0] pat_q;
  logic             accept;
  logic             last;
  logic             fail_now;
  logic [SIG_W-1:0] sig_next;

  assign s       = pat_q[3:0];
  assign L       = pat_q[6:4];
  assign pat_idx = pat_q;

  assign accept = start && (state != RUN);
  assign last   = (state == RUN) && (pat_q == PAT_LAST);

  // The verdict is registered on the wrap edge, so it looks at the MISR's incoming value.
  assign sig_next = {signature[SIG_W-2:0], 1'b0}
                  ^ ((signature[SIG_W-1] ^ n) ? SIG_POLY : '0);

  bist_misr #(
    .SIG_W    (SIG_W),
    .SIG_POLY (SIG_POLY),
    .SIG_INIT (SIG_INIT)
  ) u_misr (
    .clk      (clk),
    .rst_n    (rst_n),
    .init     (accept),
    .shift_en (state == RUN),
    .din      (n),
    .sig      (signature)
  );

`ifdef BIST_FAIL_CAPTURE_EN
  logic mismatch;

  assign mismatch = (state == RUN) && (n != L[2]);
  assign fail_now = fail_seen || mismatch;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fail_seen      <= 1'b0;
      first_fail_idx <= '0;
    end else if (accept) begin
      fail_seen      <= 1'b0;
      first_fail_idx <= '0;
    end else if (mismatch && !fail_seen) begin
      fail_seen      <= 1'b1;
      first_fail_idx <= pat_q;
    end
  end
`else
  assign fail_now = 1'b0;
`endif

  // NOTE: every register here uses <= so all outputs update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      pat_q <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= RUN;
            pat_q <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
            pass  <= 1'b0;
          end
        end
        RUN: begin
          pat_q <= pat_q + 1'b1;
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (sig_next == EXP_SIG) && !fail_now;
          end
        end
        default: begin
          state <= IDLE;
          pat_q <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
          pass  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_test2_bist_ctrl.sv
// Directed self-checking bench for test2_bist_ctrl; a mode-selected stub stands in for the netlist.
module tb_test2_bist_ctrl;

  localparam logic [15:0] POLY = 16'h1021;
  localparam logic [15:0] INIT = 16'hFFFF;

  // Netlist stand-in: mode 0 = good netlist (n = L[2]), 1 = stuck at 1, 2 = flipped at 0x55.
  function automatic logic resp(input int md, input logic [6:0] p);
    case (md)
      1:       return 1'b1;
      2:       return p[6] ^ (p == 7'h55);
      default: return p[6];
    endcase
  endfunction

  function automatic logic [15:0] model_sig(input int md);
    logic [15:0] sg;
    logic        fb;
    sg = INIT;
    for (int p = 0; p < 128; p++) begin
      fb = sg[15] ^ resp(md, 7'(p));
      sg = (sg << 1) ^ (fb ? POLY : 16'h0000);
    end
    return sg;
  endfunction

  localparam logic [15:0] GOLD = model_sig(0);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  s;
  logic [2:0]  L;
  logic        n;
  logic        busy, done, pass;
  logic [15:0] signature;
  logic [6:0]  pat_idx;
`ifdef BIST_FAIL_CAPTURE_EN
  logic        fail_seen;
  logic [6:0]  first_fail_idx;
`endif
  int          mode = 0;
  int          checks = 0;
  int          errors = 0;

  assign n = resp(mode, {L, s});

  always #5 clk = ~clk;

  test2_bist_ctrl #(.EXP_SIG(GOLD)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .s              (s),
    .L              (L),
    .n              (n),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .signature      (signature),
`ifdef BIST_FAIL_CAPTURE_EN
    .fail_seen      (fail_seen),
    .first_fail_idx (first_fail_idx),
`endif
    .pat_idx        (pat_idx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".s"}, 32'(s), 0);
    check({tag, ".L"}, 32'(L), 0);
    check({tag, ".pat_idx"}, 32'(pat_idx), 0);
    check({tag, ".busy"}, 32'(busy), 0);
    check({tag, ".done"}, 32'(done), 0);
    check({tag, ".pass"}, 32'(pass), 0);
    check({tag, ".signature"}, 32'(signature), 0);
`ifdef BIST_FAIL_CAPTURE_EN
    check({tag, ".fail_seen"}, 32'(fail_seen), 0);
    check({tag, ".first_fail_idx"}, 32'(first_fail_idx), 0);
`endif
  endtask

  // Pulses start, follows the run to completion and checks length, order and verdict.
  task automatic run(input int md, input int mid_at, input logic exp_pass, input string tag);
    int k;
    int bad;
    mode = md;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    bad = 0;
    while (busy && k < 300) begin
      if ({L, s} != 7'(k) || pat_idx != 7'(k)) bad++;
      k++;
      start = (k == mid_at);
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, ".busy_cycles"}, 32'(k), 128);
    check({tag, ".seq_errs"}, 32'(bad), 0);
    check({tag, ".done"}, 32'(done), 1);
    check({tag, ".busy"}, 32'(busy), 0);
    check({tag, ".pass"}, 32'(pass), 32'(exp_pass));
    check({tag, ".signature"}, 32'(signature), 32'(model_sig(md)));
    check({tag, ".pat_wrap"}, 32'(pat_idx), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_idle("reset_idle");

    run(0, -1, 1'b1, "clean");
`ifdef BIST_FAIL_CAPTURE_EN
    check("clean.fail_seen", 32'(fail_seen), 0);
`endif
    repeat (5) @(negedge clk);
    check("done_hold.done", 32'(done), 1);
    check("done_hold.signature", 32'(signature), 32'(GOLD));

    run(1, -1, 1'b0, "stuck1");
`ifdef BIST_FAIL_CAPTURE_EN
    check("stuck1.fail_seen", 32'(fail_seen), 1);
    check("stuck1.first_fail_idx", 32'(first_fail_idx), 0);
`endif

    run(2, -1, 1'b0, "flip55");
`ifdef BIST_FAIL_CAPTURE_EN
    check("flip55.fail_seen", 32'(fail_seen), 1);
    check("flip55.first_fail_idx", 32'(first_fail_idx), 32'h55);
`endif

    // Abort at pattern 40 and confirm nothing survives.
    mode = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 300 && pat_idx != 7'd40; i++) @(negedge clk);
    check("abort.reached40", 32'(pat_idx), 40);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_idle("abort");
    run(0, -1, 1'b1, "after_abort");

    // Mid-run start ignored; start in DONE restarts immediately.
    run(0, 60, 1'b1, "mid_start");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart.done", 32'(done), 0);
    check("restart.busy", 32'(busy), 1);
    check("restart.pass", 32'(pass), 0);
    check("restart.pat_idx", 32'(pat_idx), 0);
    check("restart.signature", 32'(signature), 32'(INIT));
    for (int i = 0; i < 300 && !done; i++) @(negedge clk);
    check("restart.final_done", 32'(done), 1);
    check("restart.final_sig", 32'(signature), 32'(GOLD));

    // Reset and start in the same cycle: reset wins.
    start = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    check_idle("rst_vs_start");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/test2_bist_ctrl.md
Name: test2_bist_ctrl

Overview:
- Sequential stimulus/response controller for the 7-input, 1-output test2 gate netlist.
- Drives `s[3:0]` and `L[2:0]` with an exhaustive pattern sequence and compacts the returned `n` into a MISR signature.
- Compares the final signature with an expected value and reports pass/fail.
- Sits beside the netlist in the gate-level regression harness; it is the driving and observing end of that netlist's port set.

Parameters:
- PAT_W, 7: stimulus width. `s` = pattern[3:0], `L` = pattern[6:4]. Fixed at 7 for this netlist.
- SIG_W, 16: MISR width.
- SIG_POLY, 16'h1021: MISR feedback polynomial (x^16+x^12+x^5+1).
- SIG_INIT, 16'hFFFF: MISR value loaded at start.
- EXP_SIG, 16'h0000: golden signature. Set per netlist by the harness.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: synchronous active-low reset.
- start, input, 1: single-cycle request to begin a run.
- s, output, 4: stimulus to netlist `s`. Registered.
- L, output, 3: stimulus to netlist `L`. Registered.
- n, input, 1: netlist response. Combinational from `s`/`L`.
- busy, output, 1: high while a run is in progress.
- done, output, 1: high from run completion until the next accepted start or reset.
- pass, output, 1: valid while `done`; 1 when signature == EXP_SIG.
- signature, output, SIG_W: current MISR contents.
- pat_idx, output, PAT_W: index of the pattern currently applied.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE.
  - s=0, L=0, pat_idx=0.
  - busy=0, done=0, pass=0.
  - signature=0.
- Reset applies from any state, including mid-RUN. The aborted run leaves no residue.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1: load signature=SIG_INIT, pat_idx=0, {L,s}=0, busy=1. Go to RUN.
  - Otherwise all outputs hold.
- RUN, each cycle:
  - `n` is the response to the {L,s} currently registered. No settle cycle.
  - At the edge: fb = signature[SIG_W-1] ^ n; signature = (signature<<1) ^ (fb ? SIG_POLY : 0).
  - pat_idx and {L,s} then increment by 1.
- RUN wrap-around:
  - When pat_idx == 2^PAT_W-1 (127), that cycle's `n` is compacted.
  - pat_idx and {L,s} wrap to 0. busy=0, done=1.
  - pass = (new signature == EXP_SIG), registered in the same edge.
  - Go to DONE.
- RUN length: exactly 128 cycles, start accept to done rising. Patterns are applied in order 0..127 with no gaps or repeats.
- `start` during RUN is ignored.
- DONE:
  - Outputs hold; signature is frozen.
  - start=1 clears done and pass, reinitialises as from IDLE, and goes to RUN (back-to-back runs allowed).
- start and rst_n=0 in the same cycle: reset wins.
- Response `n` is treated as 0/1 only; X handling is the bench's concern.

Optional Feature:
- Macro: BIST_FAIL_CAPTURE_EN.
- With the macro defined:
  - Extra outputs `fail_seen` (1 bit) and `first_fail_idx` (PAT_W bits), both reset to 0 and cleared on an accepted start.
  - Each RUN cycle compares `n` against a built-in golden model n_exp = L[2].
  - On the first mismatch of a run: fail_seen=1 and first_fail_idx=pat_idx, both sticky until the next start.
  - pass = (signature == EXP_SIG) && !fail_seen.
- Without the macro: neither port exists, and pass depends on the signature only.

Decomposition:
- Package test2_bist_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - PAT_W, SIG_W, SIG_POLY, SIG_INIT defaults;
  - the pattern count constant 2^PAT_W.
- One sub-module, bist_misr: a serial-input MISR with inputs clk, rst_n, init, shift_en, din and output sig[SIG_W-1:0], parameterised by SIG_W/SIG_POLY/SIG_INIT.
- The controller FSM and pattern counter live in test2_bist_ctrl.

Test Plan:
- Reset then idle 10 cycles → all outputs 0, done=0, busy=0.
- Start with the real netlist attached, EXP_SIG set to the bench model signature:
  - busy=1 for exactly 128 cycles;
  - {L,s} steps 0x00..0x7F;
  - done=1, pass=1, signature equals the bench MISR model.
- Stub n stuck at 1 (bench model signature ≠ EXP_SIG) → done=1, pass=0. With BIST_FAIL_CAPTURE_EN: fail_seen=1, first_fail_idx=0 (pattern 0 has L[2]=0).
- Stub inverting `n` only at pattern 0x55, with BIST_FAIL_CAPTURE_EN → first_fail_idx=0x55, fail_seen=1, pass=0.
- Assert rst_n=0 at pat_idx=40 → next cycle IDLE, all outputs 0. A subsequent start runs a full 128 patterns and reproduces the clean signature.
- Pulse start again at cycle 60 of a run, then again in DONE → mid-run pulse ignored (no restart, 128-cycle length kept); pulse in DONE restarts with done cleared next cycle.
